mul_mant_seq: RTL
=================

# mul_mant_seq

Iterative radix-2 mantissa multiplier for the FP32 multiply path. It accepts two N-bit significands (hidden bit included) through a valid/ready handshake and computes the 2N-bit product with one shift-add per cycle. It then normalizes the result to N bits and reports the exponent adjustment. Its outputs feed directly into the exponent-adjust stage, which combines `exp_adj` with the bias-subtracted exponent sum.

## Interface
- `N`, 24, significand width including hidden bit; product width is 2N.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `a_mant`  in  N  multiplicand significand.
- `b_mant`  in  N  multiplier significand.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `prod`  out  2N  raw unrounded product.
- `mant_norm`  out  N  normalized (and optionally rounded) significand.
- `exp_adj`  out  2  exponent increment (normalization shift plus rounding carry).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: accepting operands.
  - RUN: iterating.
  - ROUND: present only with the config macro.
  - DONE: holding the result.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `a_mant` into a 2N-bit multiplicand register and `b_mant` into the multiplier register.
  - Clear the accumulator and the iteration counter, then go to RUN.
- RUN, each cycle:
  - If multiplier LSB is 1, add the multiplicand into the accumulator (2N-bit, no carry out possible).
  - Shift the multiplicand left 1 and the multiplier right 1; counter +1.
  - After the N-th iteration, go to ROUND if compiled, else DONE.
- Normalization:
  - If `prod[2N-1]`=1: `mant_norm`=`prod[2N-1:N]`, exp_adj=1, guard=`prod[N-1]`, sticky=OR(`prod[N-2:0]`).
  - Else: `mant_norm`=`prod[2N-2:N-1]`, exp_adj=0, guard=`prod[N-2]`, sticky=OR(`prod[N-3:0]`).
- No leading-zero normalization is performed. A zero or denormal operand yields the raw shifted value, e.g. a zero operand gives `prod`=0, `mant_norm`=0, exp_adj=0.
- DONE:
  - `out_valid`=1; all outputs are held stable until `out_ready`=1.
  - On handshake, go to IDLE.
  - No new operand is accepted until IDLE; there is no overlap between operations.
- `in_ready` is combinational from state, so it is 0 in RUN, ROUND and DONE.
- Reset, including mid-operation: state goes to IDLE and any in-flight operation is discarded. Reset values:
  - `out_valid`=0, `prod`=0, `mant_norm`=0, `exp_adj`=0, `busy`=0.
  - `in_ready`=1 from the first cycle after the reset edge.
- Inputs are ignored while `rst`=1.

## Timing
- Acceptance edge T: state=RUN after T.
- Iterations occur on edges T+1..T+N.
- Without the macro: `out_valid` is high after edge T+N, so latency is N cycles (24).
- With the macro: ROUND occupies edge T+N+1, so latency is N+1 cycles (25).
- Output handshake at edge D: `out_valid` is 0 and `in_ready` is 1 after D. The earliest next acceptance is edge D+1.
- `out_valid` stays high under backpressure indefinitely; values must not change.
- `in_valid` during RUN, ROUND or DONE has no effect.

## Configuration
- `MUL_MANT_RNE_EN` defined:
  - The ROUND state applies round-to-nearest-even: increment `mant_norm` when guard && (sticky || LSB).
  - Increment overflow sets `mant_norm`=1<<(N-1) and adds 1 to `exp_adj`.
  - `exp_adj`=2 is legal in the encoding but unreachable for normalized inputs.
- Undefined: `mant_norm` is truncated, there is no ROUND state, and `exp_adj` ∈ {0,1}.

## Test plan
- 1.0×1.0, a=b=0x800000 -> `prod`=0x400000000000, `mant_norm`=0x800000, `exp_adj`=0, `out_valid` after exactly 24 (or 25 with RNE) cycles.
- 1.5×1.5, a=b=0xC00000 -> `prod`=0x900000000000, `mant_norm`=0x900000, `exp_adj`=1.
- Tie rounding, a=0x800001, b=0xC00000 -> `prod`=0x600000C00000; `mant_norm`=0xC00002 with RNE, 0xC00001 without; `exp_adj`=0.
- Max, a=b=0xFFFFFF -> `prod`=0xFFFFFE000001, `mant_norm`=0xFFFFFE, `exp_adj`=1 in both builds.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> outputs constant, `in_ready`=0, `in_valid` pulses ignored; release -> `in_ready`=1 next cycle, then back-to-back op accepted.
- Reset at iteration 12 of a=b=0xFFFFFF -> next cycle IDLE, `out_valid`=0, `prod`=0, `busy`=0, `in_ready`=1; following op 0x800000×0x800000 yields the correct result.

Source files
------------

// File: rtl/mul_mant_seq.sv
// Iterative radix-2 shift-add significand multiplier with normalization to N bits.
// Optional round-to-nearest-even stage enabled by defining MUL_MANT_RNE_EN.
module mul_mant_seq #(
    parameter int N = 24
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   a_mant_i,
    input  logic [N-1:0]   b_mant_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] prod_o,
    output logic [N-1:0]   mant_norm_o,
    output logic [1:0]     exp_adj_o,
    output logic           busy_o
);

    localparam int CNT_W = $clog2(N + 1);

`ifdef MUL_MANT_RNE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   prod_q, prod_d;
    logic [N-1:0]     mant_q, mant_d;
    logic [1:0]       exp_adj_q, exp_adj_d;

    logic [2*N-1:0]   sum;
    logic             norm_hi;
    logic [N-1:0]     norm_mant;
    logic             last_iter;

`ifdef MUL_MANT_RNE_EN
    logic             guard_q, guard_d;
    logic             sticky_q, sticky_d;
    logic             norm_guard;
    logic             norm_sticky;
    logic [N:0]       mant_inc;
    logic             round_up;
`endif

    // One partial product per cycle; sum is also the final product on the last iteration.
    assign sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_iter = (cnt_q == CNT_W'(N - 1));
    assign norm_hi   = sum[2*N-1];
    assign norm_mant = norm_hi ? sum[2*N-1:N] : sum[2*N-2:N-1];

`ifdef MUL_MANT_RNE_EN
    assign norm_guard  = norm_hi ? sum[N-1] : sum[N-2];
    assign norm_sticky = norm_hi ? (|sum[N-2:0]) : (|sum[N-3:0]);
    assign mant_inc    = {1'b0, mant_q} + (N+1)'(1);
    assign round_up    = guard_q && (sticky_q || mant_q[0]);
`endif

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign prod_o      = prod_q;
    assign mant_norm_o = mant_q;
    assign exp_adj_o   = exp_adj_q;

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mant_d    = mant_q;
        exp_adj_d = exp_adj_q;
`ifdef MUL_MANT_RNE_EN
        guard_d   = guard_q;
        sticky_d  = sticky_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    mcand_d  = {{N{1'b0}}, a_mant_i};
                    mplier_d = b_mant_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    prod_d    = sum;
                    mant_d    = norm_mant;
                    exp_adj_d = {1'b0, norm_hi};
`ifdef MUL_MANT_RNE_EN
                    guard_d   = norm_guard;
                    sticky_d  = norm_sticky;
                    state_d   = S_ROUND;
`else
                    state_d   = S_DONE;
`endif
                end
            end
`ifdef MUL_MANT_RNE_EN
            S_ROUND: begin
                if (round_up) begin
                    if (mant_inc[N]) begin
                        // Carry out of the significand renormalizes to 1.0 with one more exponent step.
                        mant_d    = {1'b1, {(N-1){1'b0}}};
                        exp_adj_d = exp_adj_q + 2'd1;
                    end else begin
                        mant_d    = mant_inc[N-1:0];
                    end
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: datapath registers are reset too, since the result outputs must read zero after reset.
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            mant_q    <= '0;
            exp_adj_q <= '0;
`ifdef MUL_MANT_RNE_EN
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            mant_q    <= mant_d;
            exp_adj_q <= exp_adj_d;
`ifdef MUL_MANT_RNE_EN
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
`endif
        end
    end

endmodule
